// File: rtl/hamming_decoder.sv
// Hamming(16,11) SECDED decoder: collects a 16-bit codeword as two bytes
// (LSW then MSW), decodes it, and presents one registered result behind a
// valid/ready handshake. Corrected and double-error words are tallied in
// saturating counters.
module hamming_decoder #(
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [10:0]       out_data,
    output logic [1:0]        out_status,
    output logic [3:0]        out_pos,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  dbl_cnt
);

    localparam int unsigned CODE_W = 16;
    localparam int unsigned DATA_W = 11;
    localparam int unsigned SYN_W  = 4;

    localparam logic [1:0] ST_CLEAN = 2'b00;
    localparam logic [1:0] ST_CORR  = 2'b01;
    localparam logic [1:0] ST_DBL   = 2'b10;

    typedef enum logic [1:0] {
        S_LSW,
        S_MSW,
        S_DEC,
        S_OUT
    } stateT;

    stateT              state;
    stateT              stateNext;
    logic [7:0]         lswReg;
    logic [7:0]         mswReg;
    logic               accept;

    logic [CODE_W-1:0]  code;
    logic [CODE_W-1:0]  fixedCode;
    logic [SYN_W-1:0]   synd;
    logic               parity;
    logic [DATA_W-1:0]  decData;
    logic [1:0]         decStatus;
    logic [SYN_W-1:0]   decPos;

    assign accept = in_valid && in_ready;

    // Next-state logic for the byte-collect / decode / present sequence
    always_comb begin
        stateNext = state;
        unique case (state)
            S_LSW:   if (accept)    stateNext = S_MSW;
            S_MSW:   if (accept)    stateNext = S_DEC;
            S_DEC:                  stateNext = S_OUT;
            S_OUT:   if (out_ready) stateNext = S_LSW;
            default:                stateNext = S_LSW;
        endcase
    end

    // Syndrome, overall parity, single-bit correction and data extraction
    always_comb begin
        code      = {mswReg, lswReg};
        synd      = '0;
        parity    = ^code;
        for (int k = 0; k < int'(SYN_W); k++) begin
            for (int i = 0; i < int'(CODE_W); i++) begin
                if (((i >> k) & 1) != 0) begin
                    synd[k] = synd[k] ^ code[i];
                end
            end
        end
        fixedCode = code;
        decStatus = ST_CLEAN;
        decPos    = '0;
        if (parity) begin
            // Odd parity means one flipped bit; syndrome 0 points at p0 itself
            fixedCode[synd] = ~code[synd];
            decStatus       = ST_CORR;
            decPos          = synd;
        end else if (synd != '0) begin
            decStatus       = ST_DBL;
        end
        decData = {fixedCode[15:9], fixedCode[7:5], fixedCode[3]};
    end

    // State register and registered handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_LSW;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= stateNext;
            in_ready  <= (stateNext == S_LSW) || (stateNext == S_MSW);
            out_valid <= (stateNext == S_OUT);
        end
    end

    // Capture the two halves of the codeword as they are accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lswReg <= '0;
            mswReg <= '0;
        end else if (accept) begin
            if (state == S_LSW) lswReg <= in_byte;
            if (state == S_MSW) mswReg <= in_byte;
        end
    end

    // Result registers, loaded once on leaving S_DEC and held through S_OUT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_status <= ST_CLEAN;
            out_pos    <= '0;
        end else if (state == S_DEC) begin
            out_data   <= decData;
            out_status <= decStatus;
            out_pos    <= decPos;
        end
    end

    // Saturating event counters, stepped together with the result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt <= '0;
            dbl_cnt  <= '0;
        end else if (state == S_DEC) begin
            if (decStatus == ST_CORR && corr_cnt != '1) corr_cnt <= corr_cnt + CNT_W'(1);
            if (decStatus == ST_DBL  && dbl_cnt  != '1) dbl_cnt  <= dbl_cnt  + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hamming_decoder.sv
// Bench for hamming_decoder: directed cases plus randomized codewords with
// 0..2 injected bit errors, checked against an index-XOR reference decoder.
module tb_hamming_decoder;

    localparam int unsigned CNT_W   = 8;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
    localparam int          DPOS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    logic              clk;
    logic              rst_n;
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;
    logic [10:0]       out_data;
    logic [1:0]        out_status;
    logic [3:0]        out_pos;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  corr_cnt;
    logic [CNT_W-1:0]  dbl_cnt;

    int checks = 0;
    int errors = 0;
    int expCorr = 0;
    int expDbl  = 0;

    hamming_decoder #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_status (out_status),
        .out_pos    (out_pos),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .corr_cnt   (corr_cnt),
        .dbl_cnt    (dbl_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Build a valid codeword: place data, then set each p(2^k) so the XOR of
    // set-bit indices is zero, then make total parity even with p0.
    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] c;
        int s;
        c = '0;
        for (int j = 0; j < 11; j++) c[DPOS[j]] = d[j];
        s = 0;
        for (int i = 0; i < 16; i++) if (c[i]) s = s ^ i;
        for (int k = 0; k < 4; k++) if (((s >> k) & 1) != 0) c[1 << k] = 1'b1;
        c[0] = ^c;
        return c;
    endfunction

    // Reference decode: syndrome is the XOR of indices of the one-bits
    task automatic refDecode(input logic [15:0] cin, output logic [10:0] d,
                             output logic [1:0] st, output logic [3:0] pos);
        logic [15:0] c;
        int s;
        int ones;
        c = cin;
        s = 0;
        ones = 0;
        for (int i = 0; i < 16; i++) if (c[i]) begin s = s ^ i; ones++; end
        if ((ones % 2) == 1) begin
            st = 2'b01; pos = 4'(s); c[s] = ~c[s];
        end else if (s != 0) begin
            st = 2'b10; pos = 4'd0;
        end else begin
            st = 2'b00; pos = 4'd0;
        end
        for (int j = 0; j < 11; j++) d[j] = c[DPOS[j]];
    endtask

    task automatic waitReady(input string tag);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 32'(in_ready), 32'd1);
    endtask

    task automatic checkReset(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),   32'd0);
        check({tag, "_out_valid"}, 32'(out_valid),  32'd0);
        check({tag, "_out_data"},  32'(out_data),   32'd0);
        check({tag, "_out_status"},32'(out_status), 32'd0);
        check({tag, "_out_pos"},   32'(out_pos),    32'd0);
        check({tag, "_corr_cnt"},  32'(corr_cnt),   32'd0);
        check({tag, "_dbl_cnt"},   32'(dbl_cnt),    32'd0);
    endtask

    // One full word: LSW, MSW, latency check, result check, optional stall, consume
    task automatic sendWord(input logic [7:0] lsw, input logic [7:0] msw, input int hold);
        logic [10:0] ed;
        logic [1:0]  es;
        logic [3:0]  ep;
        refDecode({msw, lsw}, ed, es, ep);
        if (es == 2'b01) expCorr++;
        if (es == 2'b10) expDbl++;

        waitReady("lsw_ready");
        in_byte = lsw; in_valid = 1'b1;
        @(posedge clk); #1;
        check("msw_ready", 32'(in_ready), 32'd1);
        in_byte = msw;
        @(posedge clk); #1;
        in_valid = 1'b0; in_byte = 8'($urandom);
        // Accept cycle of the MSW counts as cycle 1; the decode cycle shows no result yet
        check("dec_no_valid", 32'(out_valid), 32'd0);
        check("dec_no_ready", 32'(in_ready),  32'd0);
        @(posedge clk); #1;
        check("out_valid",  32'(out_valid),  32'd1);
        check("out_data",   32'(out_data),   32'(ed));
        check("out_status", 32'(out_status), 32'(es));
        check("out_pos",    32'(out_pos),    32'(ep));
        check("corr_cnt",   32'(corr_cnt),   32'((expCorr > CNT_MAX) ? CNT_MAX : expCorr));
        check("dbl_cnt",    32'(dbl_cnt),    32'((expDbl  > CNT_MAX) ? CNT_MAX : expDbl));
        check("out_no_ready", 32'(in_ready), 32'd0);

        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom); in_byte = 8'($urandom);
            @(posedge clk); #1;
            check("stall_valid",  32'(out_valid),  32'd1);
            check("stall_ready",  32'(in_ready),   32'd0);
            check("stall_data",   32'(out_data),   32'(ed));
            check("stall_status", 32'(out_status), 32'(es));
            check("stall_pos",    32'(out_pos),    32'(ep));
        end
        in_valid = 1'b0;

        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("consumed_valid", 32'(out_valid), 32'd0);
        check("back_to_lsw",    32'(in_ready),  32'd1);
    endtask

    initial begin
        logic [15:0] c;
        int b1;
        int b2;

        rst_n = 1'b0; in_byte = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkReset("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", 32'(in_ready), 32'd1);

        // Clean all-ones word
        sendWord(8'hFF, 8'hFF, 0);
        check("ff_data_const", 32'(out_data), 32'h7FF);
        // Single error at c12
        sendWord(8'h0F, 8'h10, 0);
        check("c12_pos_const", 32'(corr_cnt), 32'd1);
        // p0 flipped, then a double error
        sendWord(8'h01, 8'h00, 0);
        sendWord(8'h06, 8'h00, 0);
        check("dbl_cnt_const", 32'(dbl_cnt), 32'd1);
        // Backpressure: five stalled cycles with stray in_valid pulses
        sendWord(8'h0F, 8'h10, 5);

        // Reset after LSW accept discards the partial word
        waitReady("rst_lsw_ready");
        in_byte = 8'hA5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkReset("midword_reset");
        expCorr = 0; expDbl = 0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_midreset", 32'(in_ready), 32'd1);
        c = encode(11'h5A3);
        sendWord(c[7:0], c[15:8], 0);
        check("fresh_pair_data", 32'(out_data), 32'h5A3);

        // Randomized words with 0, 1 or 2 injected errors
        for (int n = 0; n < 60; n++) begin
            c = encode(11'($urandom));
            b1 = $urandom_range(0, 15);
            b2 = (b1 + $urandom_range(1, 15)) % 16;
            case ($urandom_range(0, 2))
                1: c[b1] = ~c[b1];
                2: begin c[b1] = ~c[b1]; c[b2] = ~c[b2]; end
                default: ;
            endcase
            sendWord(c[7:0], c[15:8], $urandom_range(0, 2));
        end

        // Saturation: 260 single-error words
        for (int n = 0; n < 260; n++) begin
            c = encode(11'($urandom));
            b1 = $urandom_range(0, 15);
            c[b1] = ~c[b1];
            sendWord(c[7:0], c[15:8], 0);
        end
        check("corr_saturated", 32'(corr_cnt), 32'(CNT_MAX));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
